// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared state encoding, default timing constants and counter sizing helpers
// for the button_debounce block and its per-channel debounce_channel.
package debounce_pkg;

    // Per-channel debounce FSM encoding
    localparam logic [0:0] DB_STABLE = 1'b0;
    localparam logic [0:0] DB_VERIFY = 1'b1;

    // Default timing, in TICK samples
    localparam int DEFAULT_STABLE_TICKS = 8;
    localparam int DEFAULT_HOLD_TICKS   = 500;

    // Verify counter only has to reach STABLE_TICKS-1, so $clog2(STABLE_TICKS) bits suffice.
    function automatic int cnt_width(input int stable_ticks);
        return (stable_ticks < 2) ? 1 : $clog2(stable_ticks);
    endfunction

    // Hold counter must be able to represent HOLD_TICKS itself (saturation value).
    function automatic int hold_width(input int hold_ticks);
        return (hold_ticks < 1) ? 1 : $clog2(hold_ticks + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
// One button bit: 2-FF synchroniser, STABLE/VERIFY debounce FSM with a
// verify counter qualified by TICK, registered press/release pulses and,
// when DEBOUNCE_HOLD_EN is defined, a saturating long-press hold counter.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   DB_STABLE | synchronised input matches BTN_STATE, verify counter at 0
//   DB_VERIFY | input differs from BTN_STATE, counting consecutive TICKs
//
// Optional feature macro: DEBOUNCE_HOLD_EN (BTN_HOLD tied to 0 otherwise).
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int HOLD_TICKS   = DEFAULT_HOLD_TICKS
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic TICK,
    input  logic BTN_IN,
    output logic BTN_STATE,
    output logic BTN_PRESS,
    output logic BTN_RELEASE,
    output logic BTN_HOLD
);

    localparam int               CNT_W    = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_meta;
    logic             r_sync;
    logic [0:0]       r_fsm;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    logic w_diff;
    logic w_accept;
    logic w_fall;

    assign w_diff   = (r_sync != r_level);
    // Qualifying TICK that completes verification and flips the level
    assign w_accept = TICK && (r_fsm == DB_VERIFY) && w_diff && (r_cnt == CNT_LAST);
    assign w_fall   = w_accept && r_level;

    // Two-stage synchroniser for the asynchronous pad input, runs every clock
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= BTN_IN;
            r_sync <= r_meta;
        end
    end

    // Debounce FSM and verify counter; everything frozen between TICKs
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_fsm     <= DB_STABLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            // Event pulses only live for the cycle after the accepting TICK
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (TICK) begin
                case (r_fsm)
                    DB_STABLE: begin
                        if (w_diff) begin
                            r_cnt <= CNT_ONE;
                            r_fsm <= DB_VERIFY;
                        end
                    end
                    default: begin
                        if (!w_diff) begin
                            // Input fell back before it was trusted: a glitch
                            r_cnt <= '0;
                            r_fsm <= DB_STABLE;
                        end else if (r_cnt == CNT_LAST) begin
                            r_level   <= ~r_level;
                            r_cnt     <= '0;
                            r_fsm     <= DB_STABLE;
                            r_press   <= ~r_level;
                            r_release <= r_level;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

    assign BTN_STATE   = r_level;
    assign BTN_PRESS   = r_press;
    assign BTN_RELEASE = r_release;

`ifdef DEBOUNCE_HOLD_EN
    localparam int                HOLD_W   = hold_width(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_hold;

    // Long-press timer: counts TICKs while pressed, saturates so it fires once
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_hold_cnt <= '0;
            r_hold     <= 1'b0;
        end else begin
            r_hold <= 1'b0;
            // Clearing on the accepting release TICK makes the counter read 0
            // in the same cycle BTN_STATE drops.
            if (w_fall || !r_level) begin
                r_hold_cnt <= '0;
            end else if (TICK && (r_hold_cnt != HOLD_MAX)) begin
                r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                r_hold     <= (r_hold_cnt == HOLD_PRE);
            end
        end
    end

    assign BTN_HOLD = r_hold;
`else
    // Hold timing is not built; keep the parameter referenced for lint.
    logic w_unused_hold;
    assign w_unused_hold = (HOLD_TICKS > 0);
    assign BTN_HOLD      = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// button_debounce
// Multi-channel push-button debouncer. Each bit is handled by an independent
// debounce_channel qualified by the shared TICK strobe; this level only
// replicates the channel and gathers its outputs into the WIDTH-bit buses.
// Optional feature macro: DEBOUNCE_HOLD_EN (long-press BTN_HOLD pulses).
module button_debounce
    import debounce_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int HOLD_TICKS   = DEFAULT_HOLD_TICKS
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             TICK,
    input  logic [WIDTH-1:0] BTN_IN,
    output logic [WIDTH-1:0] BTN_STATE,
    output logic [WIDTH-1:0] BTN_PRESS,
    output logic [WIDTH-1:0] BTN_RELEASE,
    output logic [WIDTH-1:0] BTN_HOLD
);

    logic [WIDTH-1:0] w_state;
    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] w_release;
    logic [WIDTH-1:0] w_hold;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .HOLD_TICKS   (HOLD_TICKS)
        ) u_ch (
            .CLOCK       (CLOCK),
            .RESET       (RESET),
            .TICK        (TICK),
            .BTN_IN      (BTN_IN[g]),
            .BTN_STATE   (w_state[g]),
            .BTN_PRESS   (w_press[g]),
            .BTN_RELEASE (w_release[g]),
            .BTN_HOLD    (w_hold[g])
        );
    end

    assign BTN_STATE   = w_state;
    assign BTN_PRESS   = w_press;
    assign BTN_RELEASE = w_release;
    assign BTN_HOLD    = w_hold;

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce
// Scenario tasks with directed timing expectations plus a randomized run,
// all compared cycle by cycle against a run-length reference model.
// Honours DEBOUNCE_HOLD_EN for the long-press expectations.
module tb_button_debounce;

    localparam int W    = 4;
    localparam int ST   = 4;
    localparam int HT   = 6;
    localparam int TDIV = 10;

    logic         clk = 1'b0;
    logic         RESET;
    logic         TICK;
    logic [W-1:0] BTN_IN;
    logic [W-1:0] BTN_STATE;
    logic [W-1:0] BTN_PRESS;
    logic [W-1:0] BTN_RELEASE;
    logic [W-1:0] BTN_HOLD;

    int checks = 0;
    int errors = 0;

    int tick_mode = 0;   // 0: every TDIV clocks, 1: constant high, 2: forced low
    int tick_div  = 0;

    always #5 clk = ~clk;

    button_debounce #(
        .WIDTH        (W),
        .STABLE_TICKS (ST),
        .HOLD_TICKS   (HT)
    ) dut (
        .CLOCK       (clk),
        .RESET       (RESET),
        .TICK        (TICK),
        .BTN_IN      (BTN_IN),
        .BTN_STATE   (BTN_STATE),
        .BTN_PRESS   (BTN_PRESS),
        .BTN_RELEASE (BTN_RELEASE),
        .BTN_HOLD    (BTN_HOLD)
    );

    // Reference model: a new level is accepted after ST consecutive TICK
    // samples (of the 2-clock delayed input) that disagree with the current level.
    logic [W-1:0] m_s1, m_s2, m_state, m_press, m_release, m_hold, m_prev;
    int           m_run  [W];
    int           m_held [W];
    int           tick_edges = 0;
    logic         m_last_tick = 1'b0;

    always @(posedge clk or posedge RESET) begin
        if (RESET) begin
            m_s1 = '0; m_s2 = '0; m_state = '0;
            m_press = '0; m_release = '0; m_hold = '0;
            m_last_tick = 1'b0;
            for (int i = 0; i < W; i++) begin m_run[i] = 0; m_held[i] = 0; end
        end else begin
            m_prev = m_state;
            m_press = '0; m_release = '0; m_hold = '0;
            m_last_tick = TICK;
            if (TICK) begin
                tick_edges++;
                for (int i = 0; i < W; i++) begin
                    if (m_s2[i] == m_state[i]) m_run[i] = 0;
                    else begin
                        m_run[i]++;
                        if (m_run[i] == ST) begin
                            m_state[i] = ~m_state[i];
                            m_run[i] = 0;
                            if (m_state[i]) m_press[i] = 1'b1;
                            else m_release[i] = 1'b1;
                        end
                    end
                end
            end
`ifdef DEBOUNCE_HOLD_EN
            for (int i = 0; i < W; i++) begin
                if (!m_state[i]) m_held[i] = 0;
                else if (m_prev[i] && TICK) begin
                    m_held[i]++;
                    if (m_held[i] == HT) m_hold[i] = 1'b1;
                end
            end
`endif
            m_s2 = m_s1;
            m_s1 = BTN_IN;
        end
    end

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (tick_mode == 0) begin
            tick_div = (tick_div + 1) % TDIV;
            TICK = (tick_div == TDIV - 1);
        end else if (tick_mode == 1) begin
            TICK = 1'b1;
        end else begin
            TICK = 1'b0;
        end
    endtask

    // Return just after a TICK edge so the next edit has a full period to settle.
    task automatic align();
        for (int k = 0; k < 2 * TDIV; k++) begin
            cyc();
            if (m_last_tick) break;
        end
    endtask

    task automatic test_reset();
        int presses, at_tick, base;
        RESET = 1'b1; BTN_IN = '1; TICK = 1'b0; tick_mode = 0; tick_div = 0;
        repeat (25) cyc();
        checks++;
        if ({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD} !== 16'h0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0000", {BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD});
        end
        RESET = 1'b0; tick_div = 0; TICK = 1'b0;
        base = tick_edges; presses = 0; at_tick = -1;
        for (int c = 0; c < 80; c++) begin
            cyc();
            checks++;
            if ({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD} !== {m_state, m_press, m_release, m_hold}) begin
                errors++; $display("FAIL reset_model t=%0t got %h exp %h", $time, {BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD}, {m_state, m_press, m_release, m_hold});
            end
            if (BTN_PRESS != '0) begin
                presses++; at_tick = tick_edges - base;
                checks++;
                if (BTN_PRESS !== 4'b1111) begin
                    errors++; $display("FAIL reset_press_bits got %b exp 1111", BTN_PRESS);
                end
            end
        end
        checks++;
        if (presses !== 1) begin errors++; $display("FAIL reset_press_count got %0d exp 1", presses); end
        checks++;
        if (at_tick !== ST) begin errors++; $display("FAIL reset_press_tick got %0d exp %0d", at_tick, ST); end
        checks++;
        if (BTN_STATE !== 4'b1111) begin errors++; $display("FAIL reset_state got %b exp 1111", BTN_STATE); end
    endtask

    task automatic test_release_all();
        BTN_IN = '0;
        for (int c = 0; c < 60; c++) begin
            cyc();
            checks++;
            if ({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD} !== {m_state, m_press, m_release, m_hold}) begin
                errors++; $display("FAIL release_model t=%0t got %h exp %h", $time, {BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD}, {m_state, m_press, m_release, m_hold});
            end
        end
        checks++;
        if (BTN_STATE !== 4'b0000) begin errors++; $display("FAIL release_state got %b exp 0000", BTN_STATE); end
    endtask

    task automatic test_press_single();
        int presses, at_tick, base;
        align();
        BTN_IN[0] = 1'b1;
        base = tick_edges; presses = 0; at_tick = -1;
        for (int c = 0; c < 60; c++) begin
            cyc();
            checks++;
            if ({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD} !== {m_state, m_press, m_release, m_hold}) begin
                errors++; $display("FAIL single_model t=%0t got %h exp %h", $time, {BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD}, {m_state, m_press, m_release, m_hold});
            end
            if (BTN_PRESS[0]) begin presses++; at_tick = tick_edges - base; end
        end
        checks++;
        if (presses !== 1) begin errors++; $display("FAIL single_press_cycles got %0d exp 1", presses); end
        checks++;
        if (at_tick !== ST) begin errors++; $display("FAIL single_press_tick got %0d exp %0d", at_tick, ST); end
        checks++;
        if (BTN_STATE !== 4'b0001) begin errors++; $display("FAIL single_state got %b exp 0001", BTN_STATE); end
    endtask

    task automatic test_glitch();
        int events, presses, at_tick, base;
        align();
        BTN_IN[1] = 1'b1;
        base = tick_edges; events = 0;
        for (int c = 0; c < 4 * TDIV && (tick_edges - base) < 3; c++) begin
            cyc();
            checks++;
            if ({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD} !== {m_state, m_press, m_release, m_hold}) begin
                errors++; $display("FAIL glitch_model t=%0t got %h exp %h", $time, {BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD}, {m_state, m_press, m_release, m_hold});
            end
            if (BTN_PRESS[1] || BTN_RELEASE[1] || BTN_STATE[1]) events++;
        end
        BTN_IN[1] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            checks++;
            if ({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD} !== {m_state, m_press, m_release, m_hold}) begin
                errors++; $display("FAIL glitch_model t=%0t got %h exp %h", $time, {BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD}, {m_state, m_press, m_release, m_hold});
            end
            if (BTN_PRESS[1] || BTN_RELEASE[1] || BTN_STATE[1]) events++;
        end
        checks++;
        if (events !== 0) begin errors++; $display("FAIL glitch_events got %0d exp 0", events); end
        align();
        BTN_IN[1] = 1'b1;
        base = tick_edges; presses = 0; at_tick = -1;
        for (int c = 0; c < 60; c++) begin
            cyc();
            checks++;
            if ({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD} !== {m_state, m_press, m_release, m_hold}) begin
                errors++; $display("FAIL glitch_model t=%0t got %h exp %h", $time, {BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD}, {m_state, m_press, m_release, m_hold});
            end
            if (BTN_PRESS[1]) begin presses++; at_tick = tick_edges - base; end
        end
        checks++;
        if (presses !== 1 || at_tick !== ST) begin
            errors++; $display("FAIL glitch_repress got count %0d tick %0d exp count 1 tick %0d", presses, at_tick, ST);
        end
    endtask

    task automatic test_bounce();
        int events, presses, at_tick, base;
        events = 0;
        align();
        for (int k = 0; k < 10; k++) begin
            BTN_IN[2] = ~BTN_IN[2];
            base = tick_edges;
            for (int c = 0; c < 2 * TDIV && tick_edges == base; c++) begin
                cyc();
                checks++;
                if ({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD} !== {m_state, m_press, m_release, m_hold}) begin
                    errors++; $display("FAIL bounce_model t=%0t got %h exp %h", $time, {BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD}, {m_state, m_press, m_release, m_hold});
                end
                if (BTN_PRESS[2] || BTN_RELEASE[2] || BTN_STATE[2]) events++;
            end
        end
        BTN_IN[2] = 1'b1;
        base = tick_edges;
        for (int c = 0; c < 3 * TDIV && (tick_edges - base) < 2; c++) begin
            cyc();
            if (BTN_PRESS[2] || BTN_RELEASE[2] || BTN_STATE[2]) events++;
        end
        tick_mode = 2; TICK = 1'b0;
        for (int c = 0; c < 100; c++) begin
            cyc();
            checks++;
            if ({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD} !== {m_state, m_press, m_release, m_hold}) begin
                errors++; $display("FAIL bounce_freeze_model t=%0t got %h exp %h", $time, {BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD}, {m_state, m_press, m_release, m_hold});
            end
            if (BTN_PRESS[2] || BTN_RELEASE[2] || BTN_STATE[2]) events++;
        end
        checks++;
        if (events !== 0) begin errors++; $display("FAIL bounce_early_events got %0d exp 0", events); end
        tick_mode = 0;
        presses = 0; at_tick = -1;
        for (int c = 0; c < 60; c++) begin
            cyc();
            checks++;
            if ({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD} !== {m_state, m_press, m_release, m_hold}) begin
                errors++; $display("FAIL bounce_model t=%0t got %h exp %h", $time, {BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD}, {m_state, m_press, m_release, m_hold});
            end
            if (BTN_PRESS[2]) begin presses++; at_tick = tick_edges - base; end
        end
        checks++;
        if (presses !== 1 || at_tick !== ST) begin
            errors++; $display("FAIL bounce_press got count %0d tick %0d exp count 1 tick %0d", presses, at_tick, ST);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] seen;
        int found;
        align();
        BTN_IN[0] = 1'b0; BTN_IN[3] = 1'b1;
        found = 0; seen = 2'b00;
        for (int c = 0; c < 60; c++) begin
            cyc();
            checks++;
            if ({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD} !== {m_state, m_press, m_release, m_hold}) begin
                errors++; $display("FAIL simul_model t=%0t got %h exp %h", $time, {BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD}, {m_state, m_press, m_release, m_hold});
            end
            if (found == 0 && (BTN_RELEASE[0] || BTN_PRESS[3])) begin
                found = 1; seen = {BTN_RELEASE[0], BTN_PRESS[3]};
            end
        end
        checks++;
        if (seen !== 2'b11) begin errors++; $display("FAIL simul_same_cycle got %b exp 11", seen); end
        checks++;
        if (BTN_STATE !== 4'b1110) begin errors++; $display("FAIL simul_state got %b exp 1110", BTN_STATE); end
    endtask

    task automatic test_hold();
        int holds, hold_cycles, rise_tick, hold_tick, base;
        BTN_IN[1] = 1'b0;
        repeat (60) cyc();
        align();
        BTN_IN[1] = 1'b1;
        base = tick_edges; holds = 0; hold_cycles = 0; rise_tick = -1; hold_tick = -1;
        for (int c = 0; c < 40 * TDIV && (tick_edges - base) < ST + 20; c++) begin
            cyc();
            checks++;
            if ({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD} !== {m_state, m_press, m_release, m_hold}) begin
                errors++; $display("FAIL hold_model t=%0t got %h exp %h", $time, {BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD}, {m_state, m_press, m_release, m_hold});
            end
            if (BTN_PRESS[1]) rise_tick = tick_edges - base;
            if (BTN_HOLD[1]) begin holds++; hold_tick = tick_edges - base; end
            if (BTN_HOLD != '0) hold_cycles++;
        end
`ifdef DEBOUNCE_HOLD_EN
        checks++;
        if (holds !== 1) begin errors++; $display("FAIL hold_count got %0d exp 1", holds); end
        checks++;
        if (rise_tick < 0 || (hold_tick - rise_tick) !== HT) begin
            errors++; $display("FAIL hold_delay got %0d exp %0d", hold_tick - rise_tick, HT);
        end
`else
        checks++;
        if (hold_cycles !== 0) begin errors++; $display("FAIL hold_disabled got %0d pulses exp 0", hold_cycles); end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) tick_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if (c == 2100) RESET = 1'b1;
            if (c == 2103) RESET = 1'b0;
            if ($urandom_range(0, (tick_mode == 1) ? 7 : 47) == 0)
                BTN_IN[$urandom_range(0, W - 1)] = ~BTN_IN[$urandom_range(0, W - 1)];
            cyc();
            checks++;
            if ({BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD} !== {m_state, m_press, m_release, m_hold}) begin
                errors++; $display("FAIL random_model t=%0t got %h exp %h", $time, {BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_HOLD}, {m_state, m_press, m_release, m_hold});
            end
        end
        tick_mode = 0;
    endtask

    initial begin
        RESET = 1'b1; TICK = 1'b0; BTN_IN = '0;
        test_reset();
        test_release_all();
        test_press_single();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
Multi-channel push-button debouncer. It consumes the periodic single-cycle sample strobe produced by the clock-enable divider and drives clean button levels plus press/release event pulses to downstream control FSMs. Raw pad inputs are synchronised into CLOCK. Each channel is qualified only on strobe cycles, so the debounce window scales with the divider setting.

Parameters:
WIDTH, 4, number of independent button channels (>=1)
STABLE_TICKS, 8, consecutive TICK samples of a new level required before it is accepted (>=2)
HOLD_TICKS, 500, TICK count a pressed level must persist before BTN_HOLD fires (used only with DEBOUNCE_HOLD_EN; >=1)

Ports:
CLOCK  input  1  system clock; all logic on rising edge
RESET  input  1  asynchronous, active-high reset
TICK  input  1  sample strobe, one CLOCK cycle wide, from the clock-enable divider
BTN_IN  input  WIDTH  raw asynchronous button levels, active-high (1 = pressed)
BTN_STATE  output  WIDTH  debounced level per channel
BTN_PRESS  output  WIDTH  one-cycle pulse on debounced 0->1
BTN_RELEASE  output  WIDTH  one-cycle pulse on debounced 1->0
BTN_HOLD  output  WIDTH  one-cycle long-press pulse (constant 0 without DEBOUNCE_HOLD_EN)

Behaviour:
- Reset: asynchronous, active-high. While RESET=1, all registers clear: synchronisers, counters, BTN_STATE=0, BTN_PRESS=0, BTN_RELEASE=0, BTN_HOLD=0. Mid-operation reset abandons any pending verification.
- Synchroniser: 2-FF chain per bit, free-running every CLOCK. The sampled value is the second stage (sync).
- Per-channel FSM has two states:
  - STABLE: sync == BTN_STATE; counter held at 0.
  - VERIFY: sync != BTN_STATE.
- FSM updates only on cycles with TICK=1. With TICK=0, counters and state are frozen.
- On TICK in STABLE with sync != state: counter goes to 1 and the channel enters VERIFY.
- On TICK in VERIFY:
  - If sync == state (glitch): counter clears to 0 and the channel returns to STABLE. No event is generated.
  - Else if counter == STABLE_TICKS-1: BTN_STATE toggles, counter clears to 0, the matching event pulse is registered, and the channel returns to STABLE.
  - Else: counter increments.
- Counter width is $clog2(STABLE_TICKS). The counter never wraps.
- Event timing: BTN_PRESS/BTN_RELEASE are registered and high for exactly one CLOCK, in the cycle where BTN_STATE changes (the cycle after the qualifying TICK edge). Pulses never last longer than one cycle, even if TICK is held high.
- Latency: a clean BTN_IN edge reaches BTN_STATE after 2 CLOCK of synchronisation, then the STABLE_TICKS-th subsequent TICK, then 1 CLOCK.
- TICK held constantly high degenerates to per-clock sampling (legal).
- Channels are fully independent. Simultaneous events on different channels assert in the same cycle.
- A button held through reset release is detected as a fresh press: one BTN_PRESS after STABLE_TICKS ticks.

Optional Feature:
Macro DEBOUNCE_HOLD_EN.
- Defined: each channel gets a hold counter of width $clog2(HOLD_TICKS+1), reset to 0. The counter increments on TICK while BTN_STATE=1 and saturates at HOLD_TICKS. When the counter reaches HOLD_TICKS, BTN_HOLD pulses for one CLOCK, exactly once per press. The counter clears in the cycle BTN_STATE returns to 0.
- Undefined: no hold counters are built and BTN_HOLD is tied to 0. The port list is unchanged.

Decomposition:
- Shared package debounce_pkg holds:
  - FSM state encoding (DB_STABLE, DB_VERIFY)
  - default STABLE_TICKS/HOLD_TICKS localparams
  - counter-width helper constants
- Natural sub-module: debounce_channel (one bit: synchroniser, FSM, counter, optional hold counter), instantiated WIDTH times in a generate loop. The top level only concatenates outputs.

Test Plan:
Common setup: WIDTH=4, STABLE_TICKS=4, HOLD_TICKS=6, TICK every 10 CLOCK.
1. RESET=1 with BTN_IN=4'b1111 -> all outputs 0 during reset. After release, exactly one BTN_PRESS=4'b1111 pulse on the 4th TICK (+1 CLOCK), and BTN_STATE=4'b1111 from then on.
2. BTN_IN[0] 0->1 held -> BTN_STATE[0] rises the cycle after the 4th qualifying TICK. BTN_PRESS[0] is high for 1 CLOCK. All other outputs stay 0.
3. Glitch: BTN_IN[1] high for 3 TICKs then low -> BTN_STATE[1] stays 0 with no pulses. A later 4-TICK assertion then produces a normal press.
4. Bounce: BTN_IN[2] toggles every TICK for 10 TICKs, then holds at 1 -> exactly one BTN_PRESS[2], 4 TICKs after the last toggle. TICK forced to 0 for 100 CLOCK mid-verify freezes progress.
5. Simultaneous: BTN_IN[0] 1->0 and BTN_IN[3] 0->1 in the same cycle -> BTN_RELEASE[0] and BTN_PRESS[3] pulse in the same CLOCK.
6. With DEBOUNCE_HOLD_EN: hold BTN_IN[1] for 20 TICKs -> one BTN_HOLD[1] pulse 6 TICKs after BTN_STATE[1] rises, and none after. Without the macro, BTN_HOLD stays 4'b0000.
